// File: rtl/rv2t_timer_bank.sv
// rv2t_timer_bank: prescaled 64-bit mtime plus NUM_CH compare channels.
// Registered bus reads; an MTIME_LO read snapshots the upper half.
module rv2t_timer_bank #(
    parameter int XLEN          = 32,
    parameter int NUM_CH        = 4,
    parameter int PRESCALE_BITS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [5:0]        rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic [63:0]              r_mtime;
    logic [31:0]              r_shadow;
    logic [PRESCALE_BITS-1:0] r_pcnt;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic                     r_ten;
    logic [63:0]              r_cmp    [NUM_CH];
    logic [XLEN-1:0]          r_period [NUM_CH];
    logic [NUM_CH-1:0]        r_chen;
    logic [NUM_CH-1:0]        r_per;
    logic [NUM_CH-1:0]        r_pend;
    logic [XLEN-1:0]          r_rd_data;

    logic              w_wr_mlo;
    logic              w_wr_mhi;
    logic              w_wr_psc;
    logic              w_wr_ctrl;
    logic              w_tick;
    logic [3:0]        w_wch;
    logic [3:0]        w_rch;
    logic              w_wch_ok;
    logic              w_rch_ok;
    logic [NUM_CH-1:0] w_wsel;
    logic [NUM_CH-1:0] w_match;
    logic [XLEN-1:0]   w_rdv;

    assign w_wr_mlo  = wr_en && (wr_addr == 6'd0);
    assign w_wr_mhi  = wr_en && (wr_addr == 6'd1);
    assign w_wr_psc  = wr_en && (wr_addr == 6'd2);
    assign w_wr_ctrl = wr_en && (wr_addr == 6'd3);

    // A PRESCALE write restarts the divider and suppresses this cycle's tick.
    assign w_tick = r_ten && !w_wr_psc && (r_pcnt == r_prescale);

    // Channel c occupies words 4+4c .. 7+4c.
    assign w_wch    = wr_addr[5:2] - 4'd1;
    assign w_rch    = rd_addr[5:2] - 4'd1;
    assign w_wch_ok = (wr_addr[5:2] != 4'd0) && (32'(w_wch) < NUM_CH);
    assign w_rch_ok = (rd_addr[5:2] != 4'd0) && (32'(w_rch) < NUM_CH);

    always_comb begin
        w_wsel  = '0;
        w_match = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wsel[c]  = wr_en && w_wch_ok && (w_wch == 4'(c));
            w_match[c] = r_chen[c] && !r_pend[c] && (r_mtime >= r_cmp[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pcnt     <= '0;
            r_prescale <= '0;
            r_ten      <= 1'b0;
        end else begin
            if (w_wr_psc)
                r_prescale <= wr_data[PRESCALE_BITS-1:0];
            if (w_wr_ctrl)
                r_ten <= wr_data[0];
            if (!r_ten || w_wr_psc || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mtime  <= '0;
            r_shadow <= '0;
        end else begin
            if (w_wr_mlo || w_wr_mhi) begin
                if (w_wr_mlo)
                    r_mtime[31:0] <= wr_data[31:0];
                if (w_wr_mhi)
                    r_mtime[63:32] <= wr_data[31:0];
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (rd_en && (rd_addr == 6'd0))
                r_shadow <= r_mtime[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cmp[c]    <= '0;
                r_period[c] <= '0;
            end
            r_chen <= '0;
            r_per  <= '0;
            r_pend <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // A compare write overrides any match in the same cycle.
                if (w_wsel[c] && (wr_addr[1] == 1'b0)) begin
                    if (wr_addr[0])
                        r_cmp[c][63:32] <= wr_data[31:0];
                    else
                        r_cmp[c][31:0] <= wr_data[31:0];
                    r_pend[c] <= 1'b0;
                end else begin
                    if (w_match[c]) begin
                        r_pend[c] <= 1'b1;
                        if (r_per[c])
                            r_cmp[c] <= r_cmp[c] + 64'(r_period[c]);
                        else
                            r_chen[c] <= 1'b0;
                    end
                    if (w_wsel[c] && (wr_addr[1:0] == 2'd2))
                        r_period[c] <= wr_data;
                    if (w_wsel[c] && (wr_addr[1:0] == 2'd3)) begin
                        r_chen[c] <= wr_data[0];
                        r_per[c]  <= wr_data[1];
                        if (wr_data[2] && !w_match[c])
                            r_pend[c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdv = '0;
        case (rd_addr)
            6'd0:    w_rdv = XLEN'(r_mtime[31:0]);
            6'd1:    w_rdv = XLEN'(r_shadow);
            6'd2:    w_rdv = XLEN'(r_prescale);
            6'd3:    w_rdv = XLEN'(r_ten);
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_rch_ok && (w_rch == 4'(c))) begin
                        case (rd_addr[1:0])
                            2'd0: w_rdv = XLEN'(r_cmp[c][31:0]);
                            2'd1: w_rdv = XLEN'(r_cmp[c][63:32]);
                            2'd2: w_rdv = r_period[c];
                            default: w_rdv = XLEN'({r_pend[c], r_per[c], r_chen[c]});
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_rd_data <= '0;
        else if (rd_en)
            r_rd_data <= w_rdv;
    end

    assign rd_data = r_rd_data;
    assign irq     = r_pend;
    assign irq_any = |r_pend;

endmodule

// File: tb/tb_rv2t_timer_bank.sv
// tb_rv2t_timer_bank: directed register-level steps with immediate assertions.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rv2t_timer_bank;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  irq;
    logic        irq_any;

    int          total;
    int          bad;
    logic [31:0] d;

    rv2t_timer_bank #(
        .XLEN(32),
        .NUM_CH(4),
        .PRESCALE_BITS(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .irq(irq),
        .irq_any(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [5:0] a, input logic [31:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        v     = rd_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_irq_any", 64'(irq_any), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        reset_n = 1'b1;
        rd(6'd0, d); chk("rst_mtime_lo", 64'(d), 64'h0);
        rd(6'd3, d); chk("rst_ctrl", 64'(d), 64'h0);
        rd(6'd7, d); chk("rst_chctrl0", 64'(d), 64'h0);

        // Register access, hold, unused bits, unmapped space
        wr(6'd2, 32'h1234);
        rd(6'd2, d); chk("prescale_rb", 64'(d), 64'h1234);
        wr(6'd2, 32'h55);
        chk("rd_hold", 64'(rd_data), 64'h1234);
        wr(6'd3, 32'hFFFF_FFFF);
        rd(6'd3, d); chk("ctrl_unused", 64'(d), 64'h1);
        wr(6'd3, 32'h0);
        wr(6'd7, 32'hFA);
        rd(6'd7, d); chk("chctrl_bits", 64'(d), 64'h2);
        wr(6'd7, 32'h0);
        wr(6'd6, 32'hDEAD_BEEF);
        rd(6'd6, d); chk("period_rb", 64'(d), 64'hDEAD_BEEF);
        wr(6'd20, 32'hABCD);
        rd(6'd20, d); chk("ch4_absent", 64'(d), 64'h0);
        rd(6'd4, d); chk("ch0_no_alias", 64'(d), 64'h0);
        rd(6'd63, d); chk("unmapped", 64'(d), 64'h0);

        // Prescaler 3: one tick every 4 cycles
        wr(6'd3, 32'h0);
        wr(6'd0, 32'h0);
        wr(6'd1, 32'h0);
        wr(6'd2, 32'h3);
        wr(6'd3, 32'h1);
        repeat (40) @(negedge clk);
        rd(6'd0, d); chk("prescale3_mtime", 64'(d), 64'd10);

        // Carry into the upper half and snapshot coherence
        wr(6'd3, 32'h0);
        wr(6'd2, 32'h0);
        wr(6'd0, 32'hFFFF_FFFE);
        wr(6'd1, 32'h0);
        wr(6'd3, 32'h1);
        @(negedge clk);
        wr(6'd3, 32'h0);
        rd(6'd0, d); chk("wrap_lo", 64'(d), 64'h0);
        rd(6'd1, d); chk("wrap_hi", 64'(d), 64'h1);
        rd(6'd0, d);
        wr(6'd1, 32'h55);
        rd(6'd1, d); chk("shadow_kept", 64'(d), 64'h1);
        rd(6'd0, d);
        rd(6'd1, d); chk("shadow_new", 64'(d), 64'h55);

        // Channel 1 one-shot at 5
        wr(6'd0, 32'h0);
        wr(6'd1, 32'h0);
        wr(6'd8, 32'd5);
        wr(6'd9, 32'h0);
        wr(6'd11, 32'h1);
        chk("ch1_idle", 64'(irq), 64'h0);
        wr(6'd0, 32'd5);
        @(negedge clk);
        chk("ch1_irq", 64'(irq), 64'h2);
        chk("ch1_irq_any", 64'(irq_any), 64'h1);
        rd(6'd11, d); chk("ch1_ctrl_pend", 64'(d), 64'h4);
        wr(6'd11, 32'h4);
        chk("ch1_w1c", 64'(irq), 64'h0);
        wr(6'd3, 32'h1);
        repeat (10) @(negedge clk);
        chk("ch1_no_refire", 64'(irq), 64'h0);
        rd(6'd11, d); chk("ch1_ctrl_clr", 64'(d), 64'h0);
        wr(6'd3, 32'h0);

        // Channel 0 periodic, 20 then every 10
        wr(6'd0, 32'h0);
        wr(6'd1, 32'h0);
        wr(6'd4, 32'd20);
        wr(6'd5, 32'h0);
        wr(6'd6, 32'd10);
        wr(6'd7, 32'h3);
        wr(6'd3, 32'h1);
        repeat (20) @(negedge clk);
        chk("ch0_before20", 64'(irq[0]), 64'h0);
        @(negedge clk);
        chk("ch0_at20", 64'(irq[0]), 64'h1);
        wr(6'd7, 32'h7);
        chk("ch0_w1c", 64'(irq[0]), 64'h0);
        rd(6'd4, d); chk("ch0_reload", 64'(d), 64'd30);
        repeat (7) @(negedge clk);
        chk("ch0_before30", 64'(irq[0]), 64'h0);
        @(negedge clk);
        chk("ch0_at30", 64'(irq[0]), 64'h1);
        wr(6'd3, 32'h0);
        wr(6'd7, 32'h4);
        chk("ch0_off", 64'(irq), 64'h0);

        // Channel 2: compare write colliding with a match
        wr(6'd0, 32'd100);
        wr(6'd1, 32'h0);
        wr(6'd12, 32'd200);
        wr(6'd13, 32'h0);
        wr(6'd15, 32'h1);
        wr(6'd0, 32'd250);
        wr(6'd12, 32'd500);
        @(negedge clk);
        chk("ch2_cmp_wins", 64'(irq), 64'h0);
        rd(6'd12, d); chk("ch2_cmp_val", 64'(d), 64'd500);

        // Channel 3: W1C colliding with a new match
        wr(6'd16, 32'd300);
        wr(6'd17, 32'h0);
        wr(6'd19, 32'h1);
        wr(6'd0, 32'd300);
        wr(6'd19, 32'h5);
        chk("ch3_match_wins", 64'(irq), 64'h8);

        // All four pending, then reset with a read and write in flight
        wr(6'd0, 32'd600);
        wr(6'd7, 32'h1);
        wr(6'd11, 32'h1);
        @(negedge clk);
        chk("all_pending", 64'(irq), 64'hF);
        reset_n = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 6'd0;
        wr_en   = 1'b1;
        wr_addr = 6'd2;
        wr_data = 32'h7;
        @(negedge clk);
        reset_n = 1'b1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        chk("rst2_irq", 64'(irq), 64'h0);
        chk("rst2_irq_any", 64'(irq_any), 64'h0);
        chk("rst2_rd_data", 64'(rd_data), 64'h0);
        rd(6'd0, d); chk("rst2_mtime", 64'(d), 64'h0);
        rd(6'd2, d); chk("rst2_prescale", 64'(d), 64'h0);
        rd(6'd12, d); chk("rst2_cmp2", 64'(d), 64'h0);
        rd(6'd15, d); chk("rst2_chctrl2", 64'(d), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv2t_timer_bank.md
RV2T_TIMER_BANK -- requirements
Module: rv2t_timer_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and bus data width.
REQ-002 SHALL have parameter NUM_CH, default 4, legal 1..15: number of compare channels.
REQ-003 SHALL have parameter PRESCALE_BITS, default 16: prescaler width, at most XLEN.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1: register write strobe.
REQ-007 SHALL have port wr_addr, input, 6: word address of the write.
REQ-008 SHALL have port wr_data, input, XLEN: write data.
REQ-009 SHALL have port rd_en, input, 1: register read strobe.
REQ-010 SHALL have port rd_addr, input, 6: word address of the read.
REQ-011 SHALL have port rd_data, output, XLEN: registered read data.
REQ-012 SHALL have port irq, output, NUM_CH: per-channel interrupt (pending bit).
REQ-013 SHALL have port irq_any, output, 1: OR-reduction of irq.

Function
REQ-014 SHALL decode this register map: 0 MTIME_LO; 1 MTIME_HI; 2 PRESCALE; 3 CTRL (bit0 timer_en); channel c at base 4+4c: CMP_LO, CMP_HI, PERIOD, CH_CTRL (bit0 ch_en, bit1 periodic, bit2 pending).
REQ-015 SHALL implement mtime as a 64-bit counter that increments by 1 on each tick and wraps from all-ones to 0.
REQ-016 SHALL implement the prescaler counter: held at 0 while timer_en=0; otherwise counts 0..PRESCALE and emits a one-cycle tick when equal to PRESCALE, then returns to 0. PRESCALE=0 gives a tick every cycle.
REQ-017 SHALL zero the prescaler counter on a PRESCALE write, with no tick in that cycle.
REQ-018 SHALL let writes to MTIME_LO and MTIME_HI load the corresponding half; on the same cycle as a tick, the write wins and no increment occurs.
REQ-019 SHALL evaluate each channel every cycle: match = ch_en & !pending & (mtime >= cmp), unsigned 64-bit.
REQ-020 SHALL, on a match, set pending the next cycle; if periodic=1, also set cmp <= cmp + zero-extended PERIOD (mod 2^64); if periodic=0, also clear ch_en.
REQ-021 SHALL clear pending on a write to CMP_LO or CMP_HI; such a write in the same cycle as a match wins (cmp loaded, pending=0, no reload).
REQ-022 SHALL clear pending when CH_CTRL is written with bit2=1 (W1C); bits 0-1 are written directly. A W1C in the same cycle as a new match leaves pending=1.
REQ-023 SHALL drive irq[c] = pending[c], registered, and irq_any combinationally from irq.
REQ-024 SHALL update rd_data one cycle after rd_en=1 and hold it while rd_en=0.
REQ-025 SHALL snapshot mtime[63:32] into a shadow register on a MTIME_LO read; a MTIME_HI read SHALL return the shadow, giving a coherent 64-bit pair.
REQ-026 SHALL read 0 from unmapped addresses and channels >= NUM_CH, ignore writes to them, and read unused CTRL/CH_CTRL bits as 0.

Reset
REQ-027 SHALL, with reset_n=0 at a clk edge, zero mtime, the shadow, the prescaler counter, PRESCALE, CTRL, all CMP/PERIOD/CH_CTRL fields, rd_data, irq and irq_any.
REQ-028 SHALL give reset priority over any write, read or match in the same cycle, and SHALL discard an in-flight read.

Verification
REQ-029 PRESCALE=3, CTRL=1 -> mtime increments every 4 cycles; reads after 40 cycles give 10 (+/-1 for write alignment).
REQ-030 Ch0 CMP=20, periodic=1, PERIOD=10, ch_en=1, PRESCALE=0 -> irq[0] rises the cycle after mtime reaches 20; after W1C, CMP_LO reads 30 and irq[0] returns at mtime=30.
REQ-031 Ch1 one-shot, CMP=5 -> irq[1]=1 and CH_CTRL reads 0b100; after W1C no further irq[1] while mtime keeps counting.
REQ-032 Load mtime=0x0000_0000_FFFF_FFFE and tick twice -> MTIME_LO read returns 0, then MTIME_HI returns 1; with an MTIME_HI write between the two reads, the second read still returns the snapshot.
REQ-033 CMP_LO write coinciding with a match -> pending stays 0 and the new compare value holds; reset_n=0 with irq=0xF -> next cycle irq=0, rd_data=0, mtime=0.
